mem_pipe_stage: RTL and testbench
=================================

MEM_PIPE_STAGE -- requirements
Module: mem_pipe_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data bus width, legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-003 SHALL have parameter RA_W, default 5, destination register index width.
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the upstream handshake.
REQ-007 SHALL have port flush, input, 1, kills the incoming instruction.
REQ-008 SHALL have inputs ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_load_ext (each 1), ex_dsize (2), ex_rd (RA_W), ex_alu_out (ADDR_W), ex_store_data (DATA_W).
REQ-009 SHALL have outputs dm_req (1), dm_we (1), dm_addr (ADDR_W), dm_be (DATA_W/8) and dm_wdata (DATA_W), and inputs dm_rdata (DATA_W) and dm_ack (1).
REQ-010 SHALL have outputs wb_valid (1), wb_reg_wr (1), wb_rd (RA_W), wb_data (DATA_W) and mem_busy (1).

Function
REQ-011 SHALL implement the states EMPTY, ACCESS and FULL.
REQ-012 in_ready SHALL be 1 in EMPTY and FULL, and 0 in ACCESS; mem_busy SHALL equal the inverse of in_ready.
REQ-013 An accept occurs when in_valid&in_ready&!flush; on an accept, the stage SHALL register all ex_* fields.
REQ-014 An accept with ex_mem_rd|ex_mem_wr and a legal dsize SHALL go to ACCESS; any other accept SHALL go to FULL, with wb_data=ex_alu_out.
REQ-015 In ACCESS, dm_req SHALL be 1 and dm_addr, dm_we, dm_be and dm_wdata SHALL stay stable until the cycle dm_ack=1; that cycle SHALL capture the formatted load data and go to FULL.
REQ-016 FULL SHALL assert wb_valid for exactly one cycle, then go to ACCESS or FULL on a new accept in that cycle, otherwise to EMPTY.
REQ-017 Latency: non-memory instructions 1 cycle from accept to wb_valid; memory instructions 1 cycle plus the cycles until dm_ack.
REQ-018 dsize encoding: 00 byte, 01 half, 11 word, 10 dword (DATA_W=64 only; reserved when DATA_W=32).
REQ-019 A reserved dsize SHALL perform no memory access, go to FULL and produce wb_data=0.
REQ-020 Lanes SHALL be little-endian, with offset = dm_addr low log2(DATA_W/8) bits.
REQ-021 For stores, dm_be SHALL be the size mask shifted by the offset aligned down to the access size, and dm_wdata SHALL be the store data replicated across all lanes.
REQ-022 For loads, the stage SHALL select the addressed lane and sign-extend when load_ext=1, otherwise zero-extend.
REQ-023 For stores, wb_reg_wr SHALL be forced to 0.
REQ-024 flush SHALL drop only the incoming instruction; an instruction in ACCESS or FULL SHALL complete unaffected.
REQ-025 in_valid and flush together SHALL result in no accept.

Reset
REQ-026 rst_n low SHALL asynchronously force state EMPTY and drive dm_req=0, dm_we=0, dm_be=0, wb_valid=0, wb_reg_wr=0, and wb_data, wb_rd, dm_addr and dm_wdata all to 0.
REQ-027 A reset during ACCESS SHALL abandon the access; a dm_ack arriving after reset SHALL be ignored in EMPTY.

Configuration
REQ-028 With MEM_PIPE_MISALIGN_TRAP_EN defined, the stage SHALL add output misalign_err (1).
REQ-029 With the macro defined, a memory access whose address is not size-aligned SHALL skip ACCESS, go to FULL with wb_reg_wr=0 and wb_data=0, and pulse misalign_err together with wb_valid.
REQ-030 Without the macro, misaligned addresses SHALL be aligned down silently and there SHALL be no misalign_err port.

Structure
REQ-031 The package mem_pipe_pkg SHALL hold the dsize encoding constants and the state enum.
REQ-032 The sub-module mem_load_align SHALL be combinational and hold the lane select/extend and store byte-enable/replicate logic.

Verification
REQ-033 ALU op: alu_out=0x1234, reg_wr=1, rd=5 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=5.
REQ-034 Byte load at addr 0x103, rdata 0x80FFFFFF, load_ext=1, dm_ack after 3 cycles -> wb_data=0xFFFFFF80 and in_ready=0 for those 3 cycles.
REQ-035 Half store of 0xBEEF at addr 0x102 -> dm_be=4'b1100, dm_wdata=0xBEEFBEEF, dm_we=1 and wb_reg_wr=0.
REQ-036 flush high with in_valid high -> no accept and wb_valid stays 0; an in-flight ACCESS still completes.
REQ-037 rst_n dropped mid-ACCESS -> dm_req=0 immediately; a later dm_ack produces no wb_valid.
REQ-038 With the trap macro: word load at 0x102 -> dm_req stays 0, and misalign_err=1 and wb_valid=1 in the same cycle.

Source files
------------

// File: rtl/mem_pipe_pkg.sv
// mem_pipe_pkg -- shared definitions for the memory pipeline stage.
//   * dsize encoding constants (byte / half / word / dword)
//   * stage state enum
//   * helpers: per-size low-address mask and size legality for a bus width
package mem_pipe_pkg;

  localparam logic [1:0] DSIZE_BYTE  = 2'b00;
  localparam logic [1:0] DSIZE_HALF  = 2'b01;
  localparam logic [1:0] DSIZE_DWORD = 2'b10;
  localparam logic [1:0] DSIZE_WORD  = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACCESS = 2'd1,
    ST_FULL   = 2'd2
  } mem_state_e;

  // Access size in bytes minus one; doubles as the misalignment mask.
  function automatic logic [2:0] dsize_low_mask(input logic [1:0] dsize);
    case (dsize)
      DSIZE_BYTE: return 3'd0;
      DSIZE_HALF: return 3'd1;
      DSIZE_WORD: return 3'd3;
      default:    return 3'd7;
    endcase
  endfunction

  // dword only exists on a 64-bit bus.
  function automatic logic dsize_legal(input logic [1:0] dsize, input int unsigned data_w);
    return (dsize != DSIZE_DWORD) || (data_w >= 64);
  endfunction

endpackage

// File: rtl/mem_pipe_stage_if.sv
// mem_pipe_stage_if -- data-memory request bus of the memory stage.
//   master (stage):  dm_req, dm_we, dm_addr, dm_be, dm_wdata out; dm_rdata, dm_ack in
//   slave  (memory): the reverse
interface mem_pipe_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_W-1:0]     dm_addr;
  logic [DATA_W/8-1:0]   dm_be;
  logic [DATA_W-1:0]     dm_wdata;
  logic [DATA_W-1:0]     dm_rdata;
  logic                  dm_ack;

  modport master (
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    input  dm_rdata, dm_ack
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    output dm_rdata, dm_ack
  );
endinterface

// File: rtl/mem_load_align.sv
// mem_load_align -- combinational lane logic for the memory stage.
//   dsize, offset (low address bits), load_ext : access description
//   store_data -> wdata (replicated on every lane), be (byte enables)
//   rdata      -> load_data (addressed lane, sign/zero extended)
// Offsets are aligned down to the access size; little-endian lanes.
// A reserved size yields be = 0, wdata = 0, load_data = 0.
module mem_load_align
  import mem_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]                  dsize,
  input  logic [$clog2(DATA_W/8)-1:0] offset,
  input  logic                        load_ext,
  input  logic [DATA_W-1:0]           store_data,
  input  logic [DATA_W-1:0]           rdata,
  output logic [DATA_W/8-1:0]         be,
  output logic [DATA_W-1:0]           wdata,
  output logic [DATA_W-1:0]           load_data
);
  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  logic                      legal;
  logic [2:0]                mask3;
  logic [OFF_W-1:0]          lane_off;
  logic [DATA_W-1:0]         lane_data;
  logic [$clog2(DATA_W)-1:0] top_idx;
  logic                      fill;

  always_comb begin
    legal     = dsize_legal(dsize, DATA_W);
    mask3     = dsize_low_mask(dsize);
    lane_off  = offset & ~mask3[OFF_W-1:0];
    lane_data = rdata >> {lane_off, 3'b000};
    // MSB index of the loaded value: (size_bytes * 8) - 1
    top_idx   = {mask3[OFF_W-1:0], 3'b111};
    be        = '0;
    wdata     = '0;
    load_data = '0;
    fill      = 1'b0;
    if (legal) begin
      for (int unsigned i = 0; i < NB; i++) begin
        be[i] = (i >= 32'(lane_off)) && (i <= 32'(lane_off) + 32'(mask3));
        // lane i carries store byte (i mod size)
        wdata[i*8 +: 8] = store_data[(i & 32'(mask3))*8 +: 8];
      end
      fill = load_ext & lane_data[top_idx];
      for (int unsigned i = 0; i < DATA_W; i++) begin
        load_data[i] = (i <= 32'(top_idx)) ? lane_data[i] : fill;
      end
    end
  end

endmodule

// File: rtl/mem_pipe_stage.sv
// mem_pipe_stage -- single-entry memory pipeline stage (EMPTY/ACCESS/FULL).
//   clk, rst_n           : rising-edge clock, async active-low reset
//   in_valid/in_ready    : upstream handshake; flush kills the incoming op
//   ex_*                 : instruction fields from execute
//   dm (master modport)  : data-memory bus, held stable until dm_ack
//   wb_*                 : one-cycle writeback result; mem_busy = ~in_ready
// Build option: MEM_PIPE_MISALIGN_TRAP_EN adds misalign_err and makes
// misaligned accesses skip the memory; otherwise they are aligned down.
module mem_pipe_stage
  import mem_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RA_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic              ex_mem_rd,
  input  logic              ex_mem_wr,
  input  logic              ex_reg_wr,
  input  logic              ex_load_ext,
  input  logic [1:0]        ex_dsize,
  input  logic [RA_W-1:0]   ex_rd,
  input  logic [ADDR_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_store_data,
  mem_pipe_stage_if.master  dm,
  output logic              wb_valid,
  output logic              wb_reg_wr,
  output logic [RA_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_busy
`ifdef MEM_PIPE_MISALIGN_TRAP_EN
  ,
  output logic              misalign_err
`endif
);
  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  mem_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic              reg_wr_q, reg_wr_d;
  logic              load_ext_q, load_ext_d;
  logic [1:0]        dsize_q, dsize_d;
  logic [RA_W-1:0]   rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] sdata_q, sdata_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
`ifdef MEM_PIPE_MISALIGN_TRAP_EN
  logic              misal_q, misal_d;
  logic [2:0]        ex_mask;
`endif

  logic              accept;
  logic              ex_mem_op;
  logic              ex_legal;
  logic              ex_misal;
  logic [NB-1:0]     al_be;
  logic [DATA_W-1:0] al_wdata;
  logic [DATA_W-1:0] al_load;

  // Lane logic works from the registered fields so the bus stays stable
  // for the whole access.
  mem_load_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .dsize      (dsize_q),
    .offset     (addr_q[OFF_W-1:0]),
    .load_ext   (load_ext_q),
    .store_data (sdata_q),
    .rdata      (dm.dm_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  assign in_ready  = (state_q != ST_ACCESS);
  assign mem_busy  = ~in_ready;
  assign accept    = in_valid & in_ready & ~flush;
  assign ex_mem_op = ex_mem_rd | ex_mem_wr;
  assign ex_legal  = dsize_legal(ex_dsize, DATA_W);

`ifdef MEM_PIPE_MISALIGN_TRAP_EN
  assign ex_mask  = dsize_low_mask(ex_dsize);
  assign ex_misal = ex_mem_op & ex_legal &
                    ((ex_alu_out[OFF_W-1:0] & ex_mask[OFF_W-1:0]) != '0);
`else
  assign ex_misal = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    reg_wr_d   = reg_wr_q;
    load_ext_d = load_ext_q;
    dsize_d    = dsize_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    sdata_d    = sdata_q;
    wb_data_d  = wb_data_q;
`ifdef MEM_PIPE_MISALIGN_TRAP_EN
    misal_d    = misal_q;
`endif

    case (state_q)
      ST_ACCESS: begin
        if (dm.dm_ack) begin
          state_d = ST_FULL;
          if (!we_q) wb_data_d = al_load;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Accept only happens outside ACCESS, so it overrides the drain above
    // and gives FULL -> ACCESS/FULL back-to-back.
    if (accept) begin
      we_d       = ex_mem_wr;
      reg_wr_d   = ex_reg_wr & ~ex_mem_wr & ~ex_misal;
      load_ext_d = ex_load_ext;
      dsize_d    = ex_dsize;
      rd_d       = ex_rd;
      addr_d     = ex_alu_out;
      sdata_d    = ex_store_data;
      wb_data_d  = '0;
      state_d    = ST_FULL;
`ifdef MEM_PIPE_MISALIGN_TRAP_EN
      misal_d    = ex_misal;
`endif
      if (!ex_mem_op) begin
        wb_data_d = DATA_W'(ex_alu_out);
      end else if (ex_legal && !ex_misal) begin
        state_d = ST_ACCESS;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      we_q       <= 1'b0;
      reg_wr_q   <= 1'b0;
      load_ext_q <= 1'b0;
      dsize_q    <= '0;
      rd_q       <= '0;
      addr_q     <= '0;
      sdata_q    <= '0;
      wb_data_q  <= '0;
`ifdef MEM_PIPE_MISALIGN_TRAP_EN
      misal_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      reg_wr_q   <= reg_wr_d;
      load_ext_q <= load_ext_d;
      dsize_q    <= dsize_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      sdata_q    <= sdata_d;
      wb_data_q  <= wb_data_d;
`ifdef MEM_PIPE_MISALIGN_TRAP_EN
      misal_q    <= misal_d;
`endif
    end
  end

  assign dm.dm_req   = (state_q == ST_ACCESS);
  assign dm.dm_we    = (state_q == ST_ACCESS) & we_q;
  assign dm.dm_addr  = addr_q;
  assign dm.dm_be    = (state_q == ST_ACCESS) ? al_be : '0;
  assign dm.dm_wdata = al_wdata;

  assign wb_valid  = (state_q == ST_FULL);
  assign wb_reg_wr = reg_wr_q;
  assign wb_rd     = rd_q;
  assign wb_data   = wb_data_q;

`ifdef MEM_PIPE_MISALIGN_TRAP_EN
  assign misalign_err = misal_q & (state_q == ST_FULL);
`endif

endmodule

// File: tb/tb_mem_pipe_stage.sv
// tb_mem_pipe_stage -- self-checking bench for mem_pipe_stage (32-bit bus).
// Directed cases followed by randomized instructions checked against a
// transaction-level reference model. Works with or without
// MEM_PIPE_MISALIGN_TRAP_EN defined.
module tb_mem_pipe_stage;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned RW = 5;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          flush;
  logic          ex_mem_rd;
  logic          ex_mem_wr;
  logic          ex_reg_wr;
  logic          ex_load_ext;
  logic [1:0]    ex_dsize;
  logic [RW-1:0] ex_rd;
  logic [AW-1:0] ex_alu_out;
  logic [DW-1:0] ex_store_data;
  logic          wb_valid;
  logic          wb_reg_wr;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          mem_busy;
`ifdef MEM_PIPE_MISALIGN_TRAP_EN
  logic          misalign_err;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  mem_pipe_stage_if #(.DATA_W(DW), .ADDR_W(AW)) dm_if ();

  mem_pipe_stage #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .RA_W   (RW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .flush         (flush),
    .ex_mem_rd     (ex_mem_rd),
    .ex_mem_wr     (ex_mem_wr),
    .ex_reg_wr     (ex_reg_wr),
    .ex_load_ext   (ex_load_ext),
    .ex_dsize      (ex_dsize),
    .ex_rd         (ex_rd),
    .ex_alu_out    (ex_alu_out),
    .ex_store_data (ex_store_data),
    .dm            (dm_if),
    .wb_valid      (wb_valid),
    .wb_reg_wr     (wb_reg_wr),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .mem_busy      (mem_busy)
`ifdef MEM_PIPE_MISALIGN_TRAP_EN
    ,
    .misalign_err  (misalign_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned nbytes(input logic [1:0] ds);
    case (ds)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b11:   return 4;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned aligned_off(input logic [31:0] addr, input int unsigned n);
    int unsigned off;
    off = addr % (DW / 8);
    return off - (off % n);
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] addr, input int unsigned n);
    logic [63:0] m;
    m = ((64'd1 << n) - 64'd1) << aligned_off(addr, n);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] sd, input int unsigned n);
    logic [31:0] w;
    w = '0;
    for (int unsigned b = 0; b < 4; b++) w[8*b +: 8] = sd[8*(b % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdat, input logic [31:0] addr,
                                             input int unsigned n, input logic ext);
    logic [63:0] v, keep;
    v    = 64'(rdat) >> (8 * aligned_off(addr, n));
    keep = (64'd1 << (8 * n)) - 64'd1;
    v    = v & keep;
    if (ext && v[8*n-1]) v = v | ~keep;
    return v[31:0];
  endfunction

  // op: 0 = ALU, 1 = load, 2 = store
  task automatic run_instr(input int unsigned op, input logic rw, input logic ext,
                           input logic [1:0] ds, input logic [4:0] rdi,
                           input logic [31:0] addr, input logic [31:0] sd,
                           input logic [31:0] rdat, input logic fl, input int unsigned dly);
    int unsigned n;
    bit          memop, mem, mis;
    logic [31:0] exp_wb;
    logic        exp_rw;

    chk("idle_ready", 64'(in_ready), 64'(1));
    ex_mem_rd     = (op == 1);
    ex_mem_wr     = (op == 2);
    ex_reg_wr     = rw;
    ex_load_ext   = ext;
    ex_dsize      = ds;
    ex_rd         = rdi;
    ex_alu_out    = addr;
    ex_store_data = sd;
    in_valid      = 1'b1;
    flush         = fl;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;

    if (fl) begin
      chk("flush_no_wb", 64'(wb_valid), 64'(0));
      chk("flush_no_req", 64'(dm_if.dm_req), 64'(0));
      return;
    end

    n     = nbytes(ds);
    memop = (op != 0);
    mem   = memop && (n <= DW / 8);
    mis   = 1'b0;
`ifdef MEM_PIPE_MISALIGN_TRAP_EN
    mis = mem && ((addr % n) != 0);
    if (mis) mem = 1'b0;
`endif
    exp_rw = rw && (op != 2) && !mis;

    if (mem) begin
      for (int unsigned k = 0; k <= dly; k++) begin
        if (k == dly) begin
          dm_if.dm_ack   = 1'b1;
          dm_if.dm_rdata = rdat;
        end
        chk("acc_req", 64'(dm_if.dm_req), 64'(1));
        chk("acc_ready", 64'(in_ready), 64'(0));
        chk("acc_busy", 64'(mem_busy), 64'(1));
        chk("acc_addr", 64'(dm_if.dm_addr), 64'(addr));
        chk("acc_we", 64'(dm_if.dm_we), 64'(op == 2));
        chk("acc_wbv", 64'(wb_valid), 64'(0));
        if (op == 2) begin
          chk("acc_be", 64'(dm_if.dm_be), 64'(model_be(addr, n)));
          chk("acc_wdata", 64'(dm_if.dm_wdata), 64'(model_wdata(sd, n)));
        end
        // upstream noise during the access must not disturb the bus
        in_valid   = 1'($urandom);
        ex_alu_out = $urandom;
        ex_store_data = $urandom;
        step();
      end
      dm_if.dm_ack   = 1'b0;
      dm_if.dm_rdata = $urandom;
      in_valid       = 1'b0;
    end

    exp_wb = (op == 0) ? addr : 32'h0;
    if (mem && op == 1) exp_wb = model_load(rdat, addr, n, ext);
    chk("wb_valid", 64'(wb_valid), 64'(1));
    chk("wb_rd", 64'(wb_rd), 64'(rdi));
    chk("wb_reg_wr", 64'(wb_reg_wr), 64'(exp_rw));
    chk("wb_nreq", 64'(dm_if.dm_req), 64'(0));
    if (!(mem && op == 2)) chk("wb_data", 64'(wb_data), 64'(exp_wb));
`ifdef MEM_PIPE_MISALIGN_TRAP_EN
    chk("misalign_err", 64'(misalign_err), 64'(mis));
`endif
    step();
    chk("wb_one_cycle", 64'(wb_valid), 64'(0));
    chk("idle_after", 64'(in_ready), 64'(1));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
    ex_mem_rd = 1'b0; ex_mem_wr = 1'b0; ex_reg_wr = 1'b0; ex_load_ext = 1'b0;
    ex_dsize = '0; ex_rd = '0; ex_alu_out = '0; ex_store_data = '0;
    dm_if.dm_ack = 1'b0; dm_if.dm_rdata = '0;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    chk("rst_ready", 64'(in_ready), 64'(1));
    chk("rst_busy", 64'(mem_busy), 64'(0));
    chk("rst_req", 64'(dm_if.dm_req), 64'(0));
    chk("rst_we", 64'(dm_if.dm_we), 64'(0));
    chk("rst_be", 64'(dm_if.dm_be), 64'(0));
    chk("rst_addr", 64'(dm_if.dm_addr), 64'(0));
    chk("rst_wdata", 64'(dm_if.dm_wdata), 64'(0));
    chk("rst_wbv", 64'(wb_valid), 64'(0));
    chk("rst_regwr", 64'(wb_reg_wr), 64'(0));
    chk("rst_rd", 64'(wb_rd), 64'(0));
    chk("rst_wbdata", 64'(wb_data), 64'(0));
    rst_n = 1'b1;
    step();

    // ALU op, byte load with sign extension, half store, reserved dword
    run_instr(0, 1'b1, 1'b0, 2'b11, 5'd5, 32'h0000_1234, 32'h0, 32'h0, 1'b0, 0);
    run_instr(1, 1'b1, 1'b1, 2'b00, 5'd3, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 1'b0, 2);
    run_instr(2, 1'b1, 1'b0, 2'b01, 5'd4, 32'h0000_0102, 32'h0000_BEEF, 32'h0, 1'b0, 1);
    run_instr(1, 1'b1, 1'b0, 2'b10, 5'd8, 32'h0000_0200, 32'h0, 32'hFFFF_FFFF, 1'b0, 0);
    // misaligned word load (aligned down, or trapped with the macro)
    run_instr(1, 1'b1, 1'b0, 2'b11, 5'd6, 32'h0000_0102, 32'h0, 32'hDEAD_BEEF, 1'b0, 1);
    // flush with in_valid: no accept
    run_instr(0, 1'b1, 1'b0, 2'b11, 5'd7, 32'h0000_5555, 32'h0, 32'h0, 1'b1, 0);
    run_instr(1, 1'b1, 1'b0, 2'b11, 5'd7, 32'h0000_0040, 32'h0, 32'h0, 1'b1, 0);

    // flush during an in-flight access: access still completes
    ex_mem_rd = 1'b1; ex_mem_wr = 1'b0; ex_reg_wr = 1'b1; ex_load_ext = 1'b0;
    ex_dsize = 2'b11; ex_rd = 5'd9; ex_alu_out = 32'h40; in_valid = 1'b1;
    step();
    ex_alu_out = 32'h999; flush = 1'b1;
    chk("fl_acc_req", 64'(dm_if.dm_req), 64'(1));
    step();
    chk("fl_acc_req2", 64'(dm_if.dm_req), 64'(1));
    chk("fl_acc_addr", 64'(dm_if.dm_addr), 64'(32'h40));
    in_valid = 1'b0; flush = 1'b0;
    dm_if.dm_ack = 1'b1; dm_if.dm_rdata = 32'h1122_3344;
    step();
    dm_if.dm_ack = 1'b0;
    chk("fl_wbv", 64'(wb_valid), 64'(1));
    chk("fl_wbdata", 64'(wb_data), 64'(32'h1122_3344));
    chk("fl_wbrd", 64'(wb_rd), 64'(9));
    step();
    chk("fl_done", 64'(wb_valid), 64'(0));

    // back-to-back: ALU, ALU accepted in FULL, then a load accepted in FULL
    ex_mem_rd = 1'b0; ex_mem_wr = 1'b0; ex_reg_wr = 1'b1; ex_dsize = 2'b11;
    ex_rd = 5'd1; ex_alu_out = 32'hAAAA; in_valid = 1'b1;
    step();
    chk("b2b_a_v", 64'(wb_valid), 64'(1));
    chk("b2b_a_d", 64'(wb_data), 64'(32'hAAAA));
    ex_rd = 5'd2; ex_alu_out = 32'h5555;
    step();
    chk("b2b_b_v", 64'(wb_valid), 64'(1));
    chk("b2b_b_d", 64'(wb_data), 64'(32'h5555));
    chk("b2b_b_rd", 64'(wb_rd), 64'(2));
    ex_mem_rd = 1'b1; ex_load_ext = 1'b0; ex_dsize = 2'b01; ex_rd = 5'd3;
    ex_alu_out = 32'h302;
    step();
    in_valid = 1'b0;
    chk("b2b_c_req", 64'(dm_if.dm_req), 64'(1));
    chk("b2b_c_v", 64'(wb_valid), 64'(0));
    dm_if.dm_ack = 1'b1; dm_if.dm_rdata = 32'hCAFE_0000;
    step();
    dm_if.dm_ack = 1'b0;
    chk("b2b_c_d", 64'(wb_data), 64'(32'h0000_CAFE));
    step();

    // reset in the middle of an access, late ack ignored
    ex_mem_rd = 1'b1; ex_dsize = 2'b11; ex_alu_out = 32'h200; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("rma_req", 64'(dm_if.dm_req), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rma_req_drop", 64'(dm_if.dm_req), 64'(0));
    chk("rma_ready", 64'(in_ready), 64'(1));
    chk("rma_be", 64'(dm_if.dm_be), 64'(0));
    step();
    rst_n = 1'b1;
    dm_if.dm_ack = 1'b1;
    step();
    dm_if.dm_ack = 1'b0;
    chk("rma_no_wb", 64'(wb_valid), 64'(0));
    chk("rma_no_req", 64'(dm_if.dm_req), 64'(0));
    step();
    chk("rma_no_wb2", 64'(wb_valid), 64'(0));

    // randomized instructions
    for (int t = 0; t < 80; t++) begin
      run_instr($urandom_range(0, 2), 1'($urandom), 1'($urandom), 2'($urandom),
                5'($urandom), 32'($urandom), 32'($urandom), 32'($urandom),
                ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
